sdram_device_model: RTL and testbench

//  Synthesizable responder for the 16-bit single-data-rate SDRAM command bus. Decodes
//  CS/RAS/CAS/WE commands, tracks per-bank open rows, stores data in an internal array
//  and returns read data at the programmed CAS latency.

---
 rtl/sdram_pkg.sv | 44 ++++
 rtl/sdram_rd_pipe.sv | 49 ++++
 rtl/sdram_device_model.sv | 196 +++++++++++++++++++
 tb/tb_sdram_device_model.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, error codes, mode-register fields and read-pipe stage type.
// No logic; used by the device model and sdram_controller3.
// No flow control.
package sdram_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] cmd_mrs   = 4'b0000;
    localparam logic [3:0] cmd_ref   = 4'b0001;
    localparam logic [3:0] cmd_pre   = 4'b0010;
    localparam logic [3:0] cmd_act   = 4'b0011;
    localparam logic [3:0] cmd_write = 4'b0100;
    localparam logic [3:0] cmd_read  = 4'b0101;
    localparam logic [3:0] cmd_nop   = 4'b0111;

    typedef enum logic [3:0] {
        err_none     = 4'd0,
        err_no_mrs   = 4'd1,
        err_closed   = 4'd2,
        err_trcd     = 4'd3,
        err_act_open = 4'd4,
        err_ref_open = 4'd5,
        err_trfc     = 4'd6,
        err_bad_cl   = 4'd7,
        err_bad_bl   = 4'd8,
        err_undef    = 4'd9
    } err_e;

    localparam int mrs_bl_lsb  = 0;
    localparam int mrs_bl_w    = 3;
    localparam int mrs_cl_lsb  = 4;
    localparam int mrs_cl_w    = 3;
    localparam int addr_ap_bit = 10;

    typedef struct packed {
        logic        vld;
        logic [1:0]  dqm;
        logic [15:0] dat;
    } rd_stage_t;

    function automatic logic cl_supported(input logic [2:0] cl);
        return (cl == 3'd2) || (cl == 3'd3);
    endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read-data delay line: {valid, data, dqm} shifted every clock, tapped at CAS latency.
// Latency: data loaded at command edge k is presented after edge k+cl-1.
// No backpressure; one entry accepted per clock.
module sdram_rd_pipe
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cl,
    input  logic        in_vld,
    input  logic [15:0] in_dat,
    input  logic [1:0]  dqm,
    output logic [15:0] out_dat,
    output logic        out_oe
);

    rd_stage_t [2:0] stg_q;
    rd_stage_t [2:0] stg_d;
    rd_stage_t       tap;

    // DQM is captured into whichever stage is being loaded two edges before the tap.
    always_comb begin
        stg_d[0] = '0;
        if (in_vld) begin
            stg_d[0].vld = 1'b1;
            stg_d[0].dat = in_dat;
        end
        if (cl == 3'd2) stg_d[0].dqm = dqm;
        stg_d[1] = stg_q[0];
        if (cl == 3'd3) stg_d[1].dqm = dqm;
        stg_d[2] = stg_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_d;
    end

    always_comb begin
        tap     = (cl == 3'd3) ? stg_q[2] : stg_q[1];
        out_dat = '0;
        if (tap.vld) begin
            out_dat[7:0]  = tap.dqm[0] ? 8'h00 : tap.dat[7:0];
            out_dat[15:8] = tap.dqm[1] ? 8'h00 : tap.dat[15:8];
        end
        out_oe = tap.vld & ~&tap.dqm;
    end

endmodule

// File: rtl/sdram_device_model.sv
// SDRAM chip stand-in: decodes commands, tracks open rows, stores data, flags protocol errors.
// Latency: write data taken at the command edge; read data presented CL-1 edges after READ.
// No backpressure; every command is accepted, illegal ones only raise the sticky error.
module sdram_device_model
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 10,
    parameter int TRCD     = 2,
    parameter int TRFC     = 6
) (
    input  logic        CLOCK_100,
    input  logic        rst_n,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic [1:0]  DRAM_BA,
    input  logic [12:0] DRAM_ADDR,
    input  logic [1:0]  DRAM_DQM,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err,
    output logic [3:0]  err_code,
    output logic [2:0]  mode_cl,
    output logic [15:0] cnt_rd,
    output logic [15:0] cnt_wr,
    output logic [15:0] cnt_ref
);

    localparam int AW     = 2 + ROW_BITS + COL_BITS;
    localparam int TRCD_W = $clog2(TRCD + 1);
    localparam int RFC_W  = $clog2(TRFC + 1);
    localparam logic [TRCD_W-1:0] TRCD_SAT = TRCD_W'(TRCD);
    localparam logic [RFC_W-1:0]  TRFC_LD  = RFC_W'(TRFC);

    logic [3:0]                     open_q, open_d;
    logic [3:0][ROW_BITS-1:0]       row_q, row_d;
    logic [3:0][TRCD_W-1:0]         trcd_q, trcd_d;
    logic [RFC_W-1:0]               rfc_q, rfc_d;
    logic                           mode_set_q, mode_set_d;
    logic [2:0]                     mode_cl_q, mode_cl_d;
    logic [15:0]                    cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d, cnt_ref_q, cnt_ref_d;
    logic                           err_q, err_d;
    logic [3:0]                     err_code_q, err_code_d;

    logic [3:0]    cmd;
    err_e          cur_err;
    logic          acc_ok;
    logic          rd_vld;
    logic          wr_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   rd_dat;
    logic [15:0]   mem [2**AW];
    logic          unused_addr;

    assign cmd         = (!DRAM_CKE || DRAM_CS_N) ? cmd_nop : {1'b0, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
    assign mem_addr    = {DRAM_BA, row_q[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};
    assign unused_addr = ^DRAM_ADDR[12:11];

    always_comb begin
        open_d     = open_q;
        row_d      = row_q;
        trcd_d     = trcd_q;
        rfc_d      = rfc_q;
        mode_set_d = mode_set_q;
        mode_cl_d  = mode_cl_q;
        cnt_rd_d   = cnt_rd_q;
        cnt_wr_d   = cnt_wr_q;
        cnt_ref_d  = cnt_ref_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        cur_err    = err_none;
        acc_ok     = 1'b0;

        for (int b = 0; b < 4; b++) begin
            if (trcd_q[b] != TRCD_SAT) trcd_d[b] = trcd_q[b] + 1'b1;
        end
        if (rfc_q != '0) rfc_d = rfc_q - 1'b1;

        // Accesses are counted even when they turn out to be illegal.
        if (cmd == cmd_read)  cnt_rd_d = cnt_rd_q + 16'd1;
        if (cmd == cmd_write) cnt_wr_d = cnt_wr_q + 16'd1;

        if (rfc_q != '0 && cmd != cmd_nop) begin
            cur_err = err_trfc;
        end else begin
            case (cmd)
                cmd_nop: ;
                cmd_read, cmd_write: begin
                    if (!mode_set_q)                     cur_err = err_no_mrs;
                    else if (!open_q[DRAM_BA])           cur_err = err_closed;
                    else if (trcd_q[DRAM_BA] < TRCD_SAT) cur_err = err_trcd;
                    else begin
                        acc_ok = 1'b1;
                        if (DRAM_ADDR[addr_ap_bit]) open_d[DRAM_BA] = 1'b0;
                    end
                end
                cmd_act: begin
                    if (open_q[DRAM_BA]) cur_err = err_act_open;
                    else begin
                        open_d[DRAM_BA] = 1'b1;
                        row_d[DRAM_BA]  = DRAM_ADDR[ROW_BITS-1:0];
                        trcd_d[DRAM_BA] = TRCD_W'(1);
                    end
                end
                cmd_pre: begin
                    if (DRAM_ADDR[addr_ap_bit]) open_d = '0;
                    else                        open_d[DRAM_BA] = 1'b0;
                end
                cmd_ref: begin
                    if (|open_q) cur_err = err_ref_open;
                    else begin
                        cnt_ref_d = cnt_ref_q + 16'd1;
                        rfc_d     = TRFC_LD;
                    end
                end
                cmd_mrs: begin
                    if (|open_q) cur_err = err_ref_open;
                    else if (!cl_supported(DRAM_ADDR[mrs_cl_lsb +: mrs_cl_w])) cur_err = err_bad_cl;
                    else if (DRAM_ADDR[mrs_bl_lsb +: mrs_bl_w] != '0) cur_err = err_bad_bl;
                    else begin
                        mode_cl_d  = DRAM_ADDR[mrs_cl_lsb +: mrs_cl_w];
                        mode_set_d = 1'b1;
                    end
                end
                default: cur_err = err_undef;
            endcase
        end

        if (!err_q && cur_err != err_none) begin
            err_d      = 1'b1;
            err_code_d = cur_err;
        end
    end

    assign rd_vld = acc_ok && (cmd == cmd_read);
    assign wr_en  = acc_ok && (cmd == cmd_write);

    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            open_q     <= '0;
            row_q      <= '0;
            trcd_q     <= '0;
            rfc_q      <= '0;
            mode_set_q <= 1'b0;
            mode_cl_q  <= 3'd3;
            cnt_rd_q   <= '0;
            cnt_wr_q   <= '0;
            cnt_ref_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            open_q     <= open_d;
            row_q      <= row_d;
            trcd_q     <= trcd_d;
            rfc_q      <= rfc_d;
            mode_set_q <= mode_set_d;
            mode_cl_q  <= mode_cl_d;
            cnt_rd_q   <= cnt_rd_d;
            cnt_wr_q   <= cnt_wr_d;
            cnt_ref_q  <= cnt_ref_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Storage is deliberately not reset so contents survive a controller reset.
    always_ff @(posedge CLOCK_100) begin
        if (wr_en && !DRAM_DQM[0]) mem[mem_addr][7:0]  <= dq_in[7:0];
        if (wr_en && !DRAM_DQM[1]) mem[mem_addr][15:8] <= dq_in[15:8];
    end

    assign rd_dat = mem[mem_addr];

    sdram_rd_pipe u_rd_pipe (
        .clk     (CLOCK_100),
        .rst_n   (rst_n),
        .cl      (mode_cl_q),
        .in_vld  (rd_vld),
        .in_dat  (rd_dat),
        .dqm     (DRAM_DQM),
        .out_dat (dq_out),
        .out_oe  (dq_oe)
    );

    assign err      = err_q;
    assign err_code = err_code_q;
    assign mode_cl  = mode_cl_q;
    assign cnt_rd   = cnt_rd_q;
    assign cnt_wr   = cnt_wr_q;
    assign cnt_ref  = cnt_ref_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: scoreboard of expected read returns plus
// register checks for counters, mode and sticky error codes.
module tb_sdram_device_model;

    localparam logic [3:0] C_MRS = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010, C_ACT = 4'b0011,
                           C_WR  = 4'b0100, C_RD  = 4'b0101, C_UND = 4'b0110, C_NOP = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
    logic [1:0]  DRAM_BA;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_DQM;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        err;
    logic [3:0]  err_code;
    logic [2:0]  mode_cl;
    logic [15:0] cnt_rd, cnt_wr, cnt_ref;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] rd_hist[$];
    logic [15:0] model [int];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          cl = 3;

    sdram_device_model dut (
        .CLOCK_100  (clk),
        .rst_n      (rst_n),
        .DRAM_CKE   (DRAM_CKE),
        .DRAM_CS_N  (DRAM_CS_N),
        .DRAM_RAS_N (DRAM_RAS_N),
        .DRAM_CAS_N (DRAM_CAS_N),
        .DRAM_WE_N  (DRAM_WE_N),
        .DRAM_BA    (DRAM_BA),
        .DRAM_ADDR  (DRAM_ADDR),
        .DRAM_DQM   (DRAM_DQM),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .err        (err),
        .err_code   (err_code),
        .mode_cl    (mode_cl),
        .cnt_rd     (cnt_rd),
        .cnt_wr     (cnt_wr),
        .cnt_ref    (cnt_ref)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: a scheduled read must appear exactly at its due edge, nothing otherwise.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (rst_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rd_oe", {31'b0, dq_oe}, 32'd1);
                chk("rd_data", {16'b0, dq_out}, {16'b0, e.dat});
                rd_hist.push_back(dq_out);
            end else begin
                chk("idle_oe", {31'b0, dq_oe}, 32'd0);
            end
        end
    end

    function automatic int key(input logic [1:0] ba, input logic [1:0] row, input logic [9:0] col);
        return int'({ba, row, col});
    endfunction

    task automatic drive_nop();
        DRAM_CKE = 1'b1;
        {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = C_NOP;
        DRAM_BA = '0; DRAM_ADDR = '0; DRAM_DQM = '0; dq_in = '0;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic [15:0] d);
        @(negedge clk);
        DRAM_CKE = 1'b1;
        {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = c;
        DRAM_BA = ba; DRAM_ADDR = a; DRAM_DQM = dqm; dq_in = d;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_nop();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cl = 3;
    endtask

    task automatic mrs(input logic [12:0] a, input int new_cl);
        issue(C_MRS, 2'd0, a, 2'b00, 16'h0);
        if (new_cl != 0) cl = new_cl;
    endtask

    task automatic act(input logic [1:0] ba, input logic [1:0] row);
        issue(C_ACT, ba, {11'b0, row}, 2'b00, 16'h0);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [1:0] row, input logic [9:0] col, input logic ap,
                      input logic [1:0] dqm, input logic [15:0] d, input bit legal);
        logic [15:0] v;
        issue(C_WR, ba, {2'b00, ap, col}, dqm, d);
        if (legal) begin
            v = model.exists(key(ba, row, col)) ? model[key(ba, row, col)] : 16'h0;
            if (!dqm[0]) v[7:0]  = d[7:0];
            if (!dqm[1]) v[15:8] = d[15:8];
            model[key(ba, row, col)] = v;
        end
    endtask

    // mask is the DQM the bench drives at edge k+CL-2 (the command edge when CL=2).
    task automatic rd(input logic [1:0] ba, input logic [1:0] row, input logic [9:0] col, input logic ap,
                      input logic [1:0] dqm_cmd, input logic [1:0] mask, input bit legal);
        exp_t        e;
        logic [15:0] v;
        issue(C_RD, ba, {2'b00, ap, col}, dqm_cmd, 16'h0);
        if (legal) begin
            v = model.exists(key(ba, row, col)) ? model[key(ba, row, col)] : 16'h0;
            if (mask[0]) v[7:0]  = 8'h00;
            if (mask[1]) v[15:8] = 8'h00;
            e.due = cyc + cl;
            e.dat = v;
            sb.push_back(e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_dq_oe", {31'b0, dq_oe}, 32'd0);
        chk("rst_dq_out", {16'b0, dq_out}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_err_code", {28'b0, err_code}, 32'd0);
        chk("rst_mode_cl", {29'b0, mode_cl}, 32'd3);
        chk("rst_cnt_rd", {16'b0, cnt_rd}, 32'd0);
        chk("rst_cnt_wr", {16'b0, cnt_wr}, 32'd0);
        chk("rst_cnt_ref", {16'b0, cnt_ref}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read at CL=3, then byte-masked write and back-to-back reads
        mrs(13'h030, 3);
        act(2'd1, 2'd2);
        nops(1);
        wr(2'd1, 2'd2, 10'd5, 1'b0, 2'b00, 16'hBEEF, 1);
        rd(2'd1, 2'd2, 10'd5, 1'b0, 2'b00, 2'b00, 1);
        wr(2'd1, 2'd2, 10'd6, 1'b0, 2'b00, 16'hFFFF, 1);
        wr(2'd1, 2'd2, 10'd6, 1'b0, 2'b01, 16'h1234, 1);
        rd(2'd1, 2'd2, 10'd6, 1'b0, 2'b00, 2'b00, 1);
        rd(2'd1, 2'd2, 10'd5, 1'b0, 2'b00, 2'b00, 1);
        rd(2'd1, 2'd2, 10'd6, 1'b0, 2'b00, 2'b00, 1);
        rd(2'd1, 2'd2, 10'd5, 1'b0, 2'b00, 2'b10, 1);
        issue(C_NOP, 2'd0, 13'd0, 2'b10, 16'h0);
        nops(5);
        chk("s1_err", {31'b0, err}, 32'd0);
        chk("s1_cnt_wr", {16'b0, cnt_wr}, 32'd3);
        chk("s1_cnt_rd", {16'b0, cnt_rd}, 32'd5);
        chk("s2_model_12ff", {16'b0, model[key(2'd1, 2'd2, 10'd6)]}, 32'h12FF);

        // CL=2 with read mask sampled on the command edge
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        mrs(13'h020, 2);
        act(2'd0, 2'd1);
        nops(1);
        wr(2'd0, 2'd1, 10'd9, 1'b0, 2'b00, 16'hA5A5, 1);
        rd(2'd0, 2'd1, 10'd9, 1'b0, 2'b01, 2'b01, 1);
        nops(4);
        chk("cl2_mode_cl", {29'b0, mode_cl}, 32'd2);
        chk("cl2_err", {31'b0, err}, 32'd0);

        // READ to a closed bank
        do_reset();
        mrs(13'h030, 3);
        rd(2'd2, 2'd0, 10'd0, 1'b0, 2'b00, 2'b00, 0);
        nops(4);
        chk("closed_err", {31'b0, err}, 32'd1);
        chk("closed_code", {28'b0, err_code}, 32'd2);
        chk("closed_cnt_rd", {16'b0, cnt_rd}, 32'd1);

        // READ one cycle after ACT
        do_reset();
        mrs(13'h030, 3);
        act(2'd0, 2'd0);
        rd(2'd0, 2'd0, 10'd0, 1'b0, 2'b00, 2'b00, 0);
        nops(4);
        chk("trcd_code", {28'b0, err_code}, 32'd3);

        // ACT three cycles into the refresh window
        do_reset();
        mrs(13'h030, 3);
        issue(C_REF, 2'd0, 13'd0, 2'b00, 16'h0);
        nops(2);
        act(2'd0, 2'd0);
        nops(1);
        chk("trfc_code", {28'b0, err_code}, 32'd6);

        // REF followed by exactly TRFC NOPs, then a legal ACT
        do_reset();
        mrs(13'h030, 3);
        issue(C_REF, 2'd0, 13'd0, 2'b00, 16'h0);
        nops(6);
        act(2'd0, 2'd0);
        nops(1);
        chk("ref_cnt", {16'b0, cnt_ref}, 32'd1);
        chk("ref_err", {31'b0, err}, 32'd0);

        // Remaining error codes, and first-error-wins
        do_reset();
        wr(2'd0, 2'd0, 10'd0, 1'b0, 2'b00, 16'h5555, 0);
        nops(1);
        chk("no_mrs_code", {28'b0, err_code}, 32'd1);
        do_reset();
        act(2'd0, 2'd0);
        act(2'd0, 2'd1);
        issue(C_REF, 2'd0, 13'd0, 2'b00, 16'h0);
        nops(1);
        chk("act_open_first", {28'b0, err_code}, 32'd4);
        do_reset();
        act(2'd3, 2'd0);
        issue(C_REF, 2'd0, 13'd0, 2'b00, 16'h0);
        nops(1);
        chk("ref_open_code", {28'b0, err_code}, 32'd5);
        do_reset();
        mrs(13'h040, 0);
        nops(1);
        chk("bad_cl_code", {28'b0, err_code}, 32'd7);
        chk("bad_cl_keep", {29'b0, mode_cl}, 32'd3);
        do_reset();
        mrs(13'h031, 0);
        nops(1);
        chk("bad_bl_code", {28'b0, err_code}, 32'd8);
        do_reset();
        @(negedge clk);
        DRAM_CKE = 1'b0;
        {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = C_UND;
        nops(1);
        chk("cke_low_ignored", {31'b0, err}, 32'd0);
        issue(C_UND, 2'd0, 13'd0, 2'b00, 16'h0);
        nops(1);
        chk("undef_code", {28'b0, err_code}, 32'd9);

        // Controller-style 32-bit write of 0xCAFEF00D and readback, with auto-precharge
        do_reset();
        rd_hist.delete();
        mrs(13'h030, 3);
        act(2'd0, 2'd0);
        nops(1);
        wr(2'd0, 2'd0, 10'h246, 1'b0, 2'b00, 16'hF00D, 1);
        wr(2'd0, 2'd0, 10'h247, 1'b1, 2'b00, 16'hCAFE, 1);
        act(2'd0, 2'd0);
        nops(1);
        rd(2'd0, 2'd0, 10'h246, 1'b0, 2'b00, 2'b00, 1);
        rd(2'd0, 2'd0, 10'h247, 1'b1, 2'b00, 2'b00, 1);
        nops(5);
        chk("ctl_rd_count", rd_hist.size(), 32'd2);
        if (rd_hist.size() == 2) chk("ctl_data", {rd_hist[1], rd_hist[0]}, 32'hCAFEF00D);
        chk("ctl_cnt_wr", {16'b0, cnt_wr}, 32'd2);
        chk("ctl_cnt_rd", {16'b0, cnt_rd}, 32'd2);
        chk("ctl_err", {31'b0, err}, 32'd0);

        // Reset while read data is on the bus
        do_reset();
        mrs(13'h030, 3);
        act(2'd0, 2'd0);
        nops(1);
        rd(2'd0, 2'd0, 10'h246, 1'b0, 2'b00, 2'b00, 1);
        nops(2);
        @(negedge clk);
        chk("midrd_oe_before", {31'b0, dq_oe}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrd_oe_after", {31'b0, dq_oe}, 32'd0);
        chk("midrd_dq_after", {16'b0, dq_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nops(4);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
